// File: rtl/voice_mixer_pkg.sv
// Shared definitions for the voice mixer: FSM encoding, gain scaling and
// accumulator sizing.
package voice_mixer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SCALE = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam int unsigned UNITY_GAIN   = 256;
  localparam int          GAIN_SHIFT   = $clog2(UNITY_GAIN);
  localparam int          MAX_VOICES   = 8;
  localparam int          ACC_HEADROOM = 3;
  localparam int          VOLUME_BITS  = 9;

  // Three guard bits let eight full-scale voices sum without wrapping.
  function automatic int acc_bits(input int data_bits);
    return data_bits + ACC_HEADROOM;
  endfunction

endpackage

// File: rtl/voice_mixer_saturate.sv
// Signed clamp from IN_BITS down to OUT_BITS; IN_BITS must exceed OUT_BITS.
module voice_mixer_saturate #(
  parameter int IN_BITS  = 17,
  parameter int OUT_BITS = 12
) (
  input  logic [IN_BITS-1:0]  din_i,
  output logic [OUT_BITS-1:0] dout_o
);

  localparam logic [OUT_BITS-1:0] SAT_MAX = {1'b0, {(OUT_BITS-1){1'b1}}};
  localparam logic [OUT_BITS-1:0] SAT_MIN = {1'b1, {(OUT_BITS-1){1'b0}}};

  logic [IN_BITS-OUT_BITS:0] upper;
  logic                      in_range;

  // The value fits when every bit above the output sign bit copies it.
  assign upper    = din_i[IN_BITS-1:OUT_BITS-1];
  assign in_range = (&upper) | (~|upper);

  always_comb begin
    dout_o = din_i[OUT_BITS-1:0];
    if (!in_range) begin
      dout_o = din_i[IN_BITS-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/voice_mixer.sv
// Multi-voice mixer: snapshots all voices on a sample_clk rise, sums the
// enabled ones serially, applies master gain and emits a saturated sample.
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int DATA_BITS  = 12
) (
  input  logic                            main_clk,
  input  logic                            rst,
  input  logic                            sample_clk,
  input  logic [NUM_VOICES*DATA_BITS-1:0] voice_din,
  input  logic [NUM_VOICES-1:0]           voice_en,
  input  logic [VOLUME_BITS-1:0]          volume,
  // dout_valid is a one-cycle, no-backpressure pulse: dout is new exactly
  // when it is high and then holds until the next pulse.
  output logic [DATA_BITS-1:0]            dout,
  output logic                            dout_valid,
  output logic                            busy,
  output logic                            overrun,
  output logic [1:0]                      dbg_state
);

  localparam int ACC_BITS  = acc_bits(DATA_BITS);
  localparam int PROD_BITS = ACC_BITS + VOLUME_BITS + 1;
  localparam logic [2:0] IDX_LAST = 3'(NUM_VOICES - 1);

  state_e                        state_q;
  logic                          sample_clk_q;
  logic [NUM_VOICES*DATA_BITS-1:0] snap_voice_q;
  logic [NUM_VOICES-1:0]         snap_en_q;
  logic [VOLUME_BITS-1:0]        snap_vol_q;
  logic signed [ACC_BITS-1:0]    acc_q;
  logic signed [ACC_BITS-1:0]    acc_d;
  logic [2:0]                    idx_q;
  logic signed [PROD_BITS-1:0]   prod_q;
  logic signed [PROD_BITS-1:0]   prod_d;
  logic signed [PROD_BITS-1:0]   shifted;
  logic [DATA_BITS-1:0]          dout_q;
  logic                          dout_valid_q;
  logic                          overrun_q;
  logic                          rise;

  logic [DATA_BITS-1:0]          voice_arr [MAX_VOICES];
  logic [MAX_VOICES-1:0]         en_pad;
  logic signed [ACC_BITS-1:0]    addend;
  logic [DATA_BITS-1:0]          sat_out;

  assign rise = sample_clk & ~sample_clk_q;

  // Pad to eight lanes so the 3-bit index always addresses a real entry.
  for (genvar k = 0; k < MAX_VOICES; k++) begin : g_pad
    if (k < NUM_VOICES) begin : g_used
      assign voice_arr[k] = snap_voice_q[k*DATA_BITS +: DATA_BITS];
      assign en_pad[k]    = snap_en_q[k];
    end else begin : g_unused
      assign voice_arr[k] = '0;
      assign en_pad[k]    = 1'b0;
    end
  end

  always_comb begin
    addend = '0;
    if (en_pad[idx_q]) begin
      addend = {{(ACC_BITS-DATA_BITS){voice_arr[idx_q][DATA_BITS-1]}}, voice_arr[idx_q]};
    end
    acc_d   = acc_q + addend;
    prod_d  = PROD_BITS'(acc_q) * PROD_BITS'($signed({1'b0, snap_vol_q}));
    shifted = prod_q >>> GAIN_SHIFT;
  end

  voice_mixer_saturate #(
    .IN_BITS  (PROD_BITS),
    .OUT_BITS (DATA_BITS)
  ) u_saturate (
    .din_i  (shifted),
    .dout_o (sat_out)
  );

  always_ff @(posedge main_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sample_clk_q <= 1'b0;
      snap_voice_q <= '0;
      snap_en_q    <= '0;
      snap_vol_q   <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      prod_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sample_clk_q <= sample_clk;
      dout_valid_q <= 1'b0;
      // Any rise outside IDLE, including the OUT cycle, is dropped and flagged.
      if (rise && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            snap_voice_q <= voice_din;
            snap_en_q    <= voice_en;
            snap_vol_q   <= volume;
            acc_q        <= '0;
            idx_q        <= '0;
            state_q      <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 3'd1;
          if (idx_q == IDX_LAST) begin
            state_q <= ST_SCALE;
          end
        end
        ST_SCALE: begin
          prod_q  <= prod_d;
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          dout_q       <= sat_out;
          dout_valid_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != ST_IDLE);
  assign overrun    = overrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer (4 voices x 12 bits) with hand-computed results.
module tb_voice_mixer;

  logic               main_clk;
  logic               rst;
  logic               sample_clk;
  logic [47:0]        voice_din;
  logic [3:0]         voice_en;
  logic [8:0]         volume;
  logic signed [11:0] dout;
  logic               dout_valid;
  logic               busy;
  logic               overrun;
  logic [1:0]         dbg_state;

  int n_checks;
  int n_fail;
  int pulses;
  int lat;
  int got;

  voice_mixer #(
    .NUM_VOICES (4),
    .DATA_BITS  (12)
  ) dut (
    .main_clk   (main_clk),
    .rst        (rst),
    .sample_clk (sample_clk),
    .voice_din  (voice_din),
    .voice_en   (voice_en),
    .volume     (volume),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  task automatic do_reset();
    @(negedge main_clk);
    rst = 1'b1;
    repeat (2) @(negedge main_clk);
    rst = 1'b0;
  endtask

  // Checking
  task automatic check_val(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drivers
  task automatic set_voices(input int v0, input int v1, input int v2, input int v3);
    voice_din = {12'(v3), 12'(v2), 12'(v1), 12'(v0)};
  endtask

  // Watches 25 negedges starting right after the rising edge that should
  // take the snapshot; k counts clock edges since that snapshot edge.
  task automatic observe(input int drop_k);
    pulses = 0;
    lat    = -1;
    got    = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge main_clk);
      if (dout_valid) begin
        pulses++;
        lat = k;
        got = int'(dout);
      end
      if (k == drop_k) sample_clk = 1'b0;
    end
  endtask

  task automatic one_sample();
    @(negedge main_clk);
    sample_clk = 1'b1;
    observe(0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    sample_clk = 1'b0;
    voice_din  = '0;
    voice_en   = '0;
    volume     = '0;
    do_reset();

    check_val("rst_dout", int'(dout), 0);
    check_val("rst_valid", int'(dout_valid), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_overrun", int'(overrun), 0);
    check_val("rst_state", int'(dbg_state), 0);

    // Basic mix: 100+200-50+10 at unity gain
    set_voices(100, 200, -50, 10);
    voice_en = 4'b1111;
    volume   = 9'd256;
    one_sample();
    check_val("basic_dout", got, 260);
    check_val("basic_latency", lat, 6);
    check_val("basic_pulses", pulses, 1);
    check_val("basic_overrun", int'(overrun), 0);
    check_val("basic_hold", int'(dout), 260);

    // Positive and negative clamps
    set_voices(2047, 2047, 2047, 2047);
    one_sample();
    check_val("clamp_pos", got, 2047);
    check_val("clamp_pos_pulses", pulses, 1);
    set_voices(-2048, -2048, -2048, -2048);
    one_sample();
    check_val("clamp_neg", got, -2048);

    // Negative extreme passes unchanged at unity
    set_voices(-2048, 0, 0, 0);
    voice_en = 4'b0001;
    one_sample();
    check_val("neg_extreme", got, -2048);

    // Half gain on one enabled voice, then mute
    set_voices(1000, 1000, 0, 0);
    voice_en = 4'b0001;
    volume   = 9'd128;
    one_sample();
    check_val("half_gain", got, 500);
    volume = 9'd0;
    one_sample();
    check_val("mute_dout", got, 0);
    check_val("mute_pulses", pulses, 1);

    // All voices disabled
    set_voices(300, -700, 5, 9);
    voice_en = 4'b0000;
    volume   = 9'd256;
    one_sample();
    check_val("en_zero_dout", got, 0);
    check_val("en_zero_pulses", pulses, 1);

    // sample_clk held high for 20 cycles gives a single sample
    set_voices(100, 200, -50, 10);
    voice_en = 4'b1111;
    @(negedge main_clk);
    sample_clk = 1'b1;
    observe(19);
    check_val("held_pulses", pulses, 1);
    check_val("held_dout", got, 260);

    // Maximum gain: 1500*511/256 = 2994 -> clamp
    set_voices(1500, 0, 0, 0);
    voice_en = 4'b0001;
    volume   = 9'd511;
    one_sample();
    check_val("max_gain_clamp", got, 2047);
    check_val("no_overrun_yet", int'(overrun), 0);

    // Second rise two edges after the first, inputs scrambled mid-ACCUM
    set_voices(100, 200, -50, 10);
    voice_en = 4'b1111;
    volume   = 9'd256;
    @(negedge main_clk);
    sample_clk = 1'b1;
    pulses = 0;
    got    = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge main_clk);
      if (k == 0) check_val("busy_after_snap", int'(busy), 1);
      if (dout_valid) begin
        pulses++;
        got = int'(dout);
      end
      case (k)
        0: sample_clk = 1'b0;
        1: begin
          sample_clk = 1'b1;
          set_voices(-999, 7, 7, 7);
          voice_en = 4'b0101;
          volume   = 9'd3;
        end
        2: sample_clk = 1'b0;
        default: ;
      endcase
    end
    check_val("overrun_pulses", pulses, 1);
    check_val("overrun_snapshot", got, 260);
    check_val("overrun_flag", int'(overrun), 1);

    // Flag is sticky across a normal sample
    set_voices(100, 200, -50, 10);
    voice_en = 4'b1111;
    volume   = 9'd256;
    one_sample();
    check_val("sticky_dout", got, 260);
    check_val("sticky_overrun", int'(overrun), 1);

    // Reset while in SCALE aborts the sample
    set_voices(40, 40, 40, 40);
    @(negedge main_clk);
    sample_clk = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge main_clk);
      if (k == 4) check_val("in_scale_state", int'(dbg_state), 2);
      if (dout_valid) pulses++;
      case (k)
        0: sample_clk = 1'b0;
        4: rst = 1'b1;
        5: rst = 1'b0;
        default: ;
      endcase
    end
    check_val("abort_pulses", pulses, 0);
    check_val("abort_dout", int'(dout), 0);
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_overrun", int'(overrun), 0);
    check_val("abort_state", int'(dbg_state), 0);
    one_sample();
    check_val("after_abort_dout", got, 160);
    check_val("after_abort_latency", lat, 6);

    // Rise landing on the OUT cycle is ignored but flagged
    do_reset();
    set_voices(100, 200, -50, 10);
    @(negedge main_clk);
    sample_clk = 1'b1;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge main_clk);
      if (dout_valid) pulses++;
      case (k)
        0: sample_clk = 1'b0;
        5: sample_clk = 1'b1;
        6: sample_clk = 1'b0;
        default: ;
      endcase
    end
    check_val("out_rise_pulses", pulses, 1);
    check_val("out_rise_overrun", int'(overrun), 1);

    // sample_clk already high as reset releases
    set_voices(1, 2, 3, 4);
    @(negedge main_clk);
    rst        = 1'b1;
    sample_clk = 1'b1;
    repeat (2) @(negedge main_clk);
    rst = 1'b0;
    observe(3);
    check_val("rst_release_latency", lat, 6);
    check_val("rst_release_dout", got, 10);
    check_val("rst_release_pulses", pulses, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
